bicubic_weights: RTL and testbench
==================================

BICUBIC_WEIGHTS -- requirements
Module: bicubic_weights

Interface
REQ-001 The block SHALL have parameter FRAC_W, default 8, giving the fraction bits of the phase input and of the weight outputs (Q0.FRAC_W and Q.FRAC_W).
REQ-002 The block SHALL have parameter A_W, default FRAC_W+2, giving the width of the signed kernel coefficient a in Q.FRAC_W.
REQ-003 The block SHALL have parameter W_W, default FRAC_W+3, giving the width of each signed weight output.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  load cfg_a into the active coefficient register.
- cfg_a  in  A_W  signed coefficient a in Q.FRAC_W; -128 = -0.5 at default widths.
- in_valid  in  1  phase input valid.
- in_ready  out  1  phase input accepted when in_valid && in_ready.
- in_t  in  FRAC_W  unsigned fractional phase t in [0,1).
- out_valid  out  1  weight set valid.
- out_ready  in  1  downstream accepts the weight set.
- w0, w1, w2, w3  out  W_W each  signed weights for taps at distances 1+t, t, 1-t, 2-t.

Function
REQ-005 The block SHALL compute the Keys cubic kernel weights: w1 = (a+2)t^3-(a+3)t^2+1; w2 = the same with 1-t; w0 = a*d^3-5a*d^2+8a*d-4a with d=1+t; w3 = the same with d=2-t.
REQ-006 The block SHALL form intermediate products at full precision with no truncation before the final stage.
REQ-007 The final stage SHALL round each weight half-up to FRAC_W fraction bits by adding 2^(FRAC_W-1) and then arithmetic-shifting right.
REQ-008 The final stage SHALL then saturate each weight to the signed W_W range.
REQ-009 The block SHALL be a 4-stage pipeline: S1 captures t and a and forms 1-t, 1+t and 2-t; S2 forms squares; S3 forms cubes; S4 combines, rounds and saturates.
REQ-010 Latency SHALL be exactly 4 cycles from an accepted input to out_valid when not stalled.
REQ-011 Throughput SHALL be 1 weight set per cycle while out_ready=1.
REQ-012 Each pipeline stage SHALL carry a valid bit.
REQ-013 The pipeline SHALL use a global enable: en = !out_valid || out_ready.
REQ-014 in_ready SHALL equal en.
REQ-015 When en=0, all stage registers and outputs SHALL hold their values.
REQ-016 w0..w3 SHALL remain stable while out_valid=1 && out_ready=0.
REQ-017 A write with cfg_we=1 SHALL update the active coefficient register at the clock edge.
REQ-018 An input accepted in the same cycle as cfg_we SHALL use the new cfg_a value.
REQ-019 Each sample SHALL carry its own captured a through the pipeline, so in-flight samples are unaffected by later cfg writes.
REQ-020 When t=0, the weights SHALL be exactly (0, 2^FRAC_W, 0, 0) for any a, with no rounding error.
REQ-021 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT produce out_valid pulses.

Reset
REQ-022 While rst=1 at a clock edge: all stage valid bits, out_valid and w0..w3 SHALL clear to 0.
REQ-023 While rst=1 at a clock edge: the active coefficient register SHALL load -2^(FRAC_W-1), i.e. a=-0.5.
REQ-024 in_ready SHALL be 1 in the cycle after reset releases.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight samples, and no partial result SHALL be emitted afterwards.
REQ-026 cfg_we SHALL be ignored while rst=1.

Structure
REQ-027 The shared package bicubic_pkg SHALL hold the default FRAC_W, the W_W derivation, the round-half-up function and the saturate-to-W_W function.
REQ-028 One sub-module, bicubic_poly_eval, SHALL evaluate c3*d^3 + c2*d^2 + c1*d + c0 from registered powers.
REQ-029 bicubic_poly_eval SHALL be instantiated four times, with coefficient sets {a,-5a,8a,-4a} and {a+2,-(a+3),0,1}.
REQ-030 Stage-register widths SHALL be derived from the parameters, with no hard-coded 8/9-bit literals.

Verification
REQ-031 The bench SHALL cover these directed scenarios at default parameters:
- Reset, then t=0 with default a -> after 4 cycles out_valid=1 and weights (0,256,0,0).
- a=-128, t=128 -> weights (-16,144,144,-16).
- cfg_a=-256 written, then t=128 -> weights (-32,160,160,-32); a sample accepted one cycle before the write still gives (-16,144,144,-16).
- Back-to-back t=0..255 with out_ready=1 -> 256 consecutive out_valid cycles, each weight within 1 LSB of the real-valued model, and w0+w1+w2+w3 within 256±2.
- out_ready held 0 for 5 cycles with the pipe full -> in_ready=0, outputs stable, no sample lost or duplicated after release.
- rst asserted with 3 samples in flight -> out_valid=0 next cycle and no stale result emitted after release.

Source files
------------

// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared widths and fixed-point helpers for the bicubic weight generator
package bicubic_pkg;

    localparam int FRAC_W_DEF = 8;
    localparam int ACC_MAX    = 96;

    typedef logic signed [ACC_MAX-1:0] acc_t;

    function automatic int w_w_of(input int frac_w);
        return frac_w + 3;
    endfunction

    function automatic acc_t round_half_up(input acc_t x, input int sh);
        acc_t one;
        one = acc_t'(1);
        return (x + (one <<< (sh - 1))) >>> sh;
    endfunction

    function automatic acc_t sat_to_w(input acc_t x, input int w);
        acc_t one;
        acc_t hi;
        acc_t lo;
        one = acc_t'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/bicubic_poly_eval.sv
// rtl/bicubic_poly_eval.sv - full-precision c3*d^3 + c2*d^2 + c1*d + c0, result in Q.4*FRAC_W
module bicubic_poly_eval
    import bicubic_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int C_W    = FRAC_W + 6,
    parameter int D_W    = FRAC_W + 2,
    parameter int ACC_W  = C_W + 3 * D_W + 2
) (
    input  logic signed [C_W-1:0]   i_c3,
    input  logic signed [C_W-1:0]   i_c2,
    input  logic signed [C_W-1:0]   i_c1,
    input  logic signed [C_W-1:0]   i_c0,
    input  logic        [D_W-1:0]   i_d,
    input  logic        [2*D_W-1:0] i_d2,
    input  logic        [3*D_W-1:0] i_d3,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] w_c3, w_c2, w_c1, w_c0;
    logic signed [ACC_W-1:0] w_d, w_d2, w_d3;

    assign w_c3 = ACC_W'(i_c3);
    assign w_c2 = ACC_W'(i_c2);
    assign w_c1 = ACC_W'(i_c1);
    assign w_c0 = ACC_W'(i_c0);
    assign w_d  = ACC_W'($signed({1'b0, i_d}));
    assign w_d2 = ACC_W'($signed({1'b0, i_d2}));
    assign w_d3 = ACC_W'($signed({1'b0, i_d3}));

    // Each term is aligned to the Q.4F scale of the cubic term so nothing is dropped.
    assign o_acc = (w_c3 * w_d3)
                 + ((w_c2 * w_d2) <<< FRAC_W)
                 + ((w_c1 * w_d) <<< (2 * FRAC_W))
                 + (w_c0 <<< (3 * FRAC_W));

endmodule

// File: rtl/bicubic_weights.sv
// rtl/bicubic_weights.sv - 4-stage Keys cubic kernel weight pipeline with per-sample coefficient
module bicubic_weights
    import bicubic_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int A_W    = FRAC_W + 2,
    parameter int W_W    = w_w_of(FRAC_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic signed [A_W-1:0] cfg_a,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAC_W-1:0]     in_t,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [W_W-1:0] w0,
    output logic signed [W_W-1:0] w1,
    output logic signed [W_W-1:0] w2,
    output logic signed [W_W-1:0] w3
);

    localparam int D_W   = FRAC_W + 2;
    localparam int D2_W  = 2 * D_W;
    localparam int D3_W  = 3 * D_W;
    localparam int C_W   = A_W + 4;
    localparam int ACC_W = C_W + D3_W + 2;

    localparam logic        [D_W-1:0] D_ONE   = D_W'(2 ** FRAC_W);
    localparam logic        [D_W-1:0] D_TWO   = D_W'(2 ** (FRAC_W + 1));
    localparam logic signed [A_W-1:0] A_RST   = A_W'(-(2 ** (FRAC_W - 1)));
    localparam logic signed [C_W-1:0] C_ONE   = C_W'(2 ** FRAC_W);
    localparam logic signed [C_W-1:0] C_TWO   = C_W'(2 ** (FRAC_W + 1));
    localparam logic signed [C_W-1:0] C_THREE = C_W'(3 * (2 ** FRAC_W));

    logic                   w_en;
    logic signed [A_W-1:0]  w_a_in;
    logic [3:0][D_W-1:0]    w_d_in;
    logic [D_W-1:0]         w_t;
    logic [3:0][W_W-1:0]    w_res;

    logic signed [A_W-1:0]  r_a, r_s1_a, r_s2_a, r_s3_a;
    logic                   r_s1_v, r_s2_v, r_s3_v, r_out_valid;
    logic [3:0][D_W-1:0]    r_s1_d, r_s2_d, r_s3_d;
    logic [3:0][D2_W-1:0]   r_s2_sq, r_s3_sq;
    logic [3:0][D3_W-1:0]   r_s3_cu;
    logic [3:0][W_W-1:0]    r_w;

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign w0        = $signed(r_w[0]);
    assign w1        = $signed(r_w[1]);
    assign w2        = $signed(r_w[2]);
    assign w3        = $signed(r_w[3]);

    // A coefficient written in the accepting cycle applies to that sample.
    assign w_a_in = cfg_we ? cfg_a : r_a;
    assign w_t    = D_W'(in_t);

    always_comb begin
        w_d_in    = '0;
        w_d_in[0] = D_ONE + w_t;
        w_d_in[1] = w_t;
        w_d_in[2] = D_ONE - w_t;
        w_d_in[3] = D_TWO - w_t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= A_RST;
            r_s1_v      <= 1'b0;
            r_s2_v      <= 1'b0;
            r_s3_v      <= 1'b0;
            r_out_valid <= 1'b0;
            r_w         <= '0;
        end else begin
            if (cfg_we) begin
                r_a <= cfg_a;
            end
            if (w_en) begin
                r_s1_v <= in_valid;
                r_s1_a <= w_a_in;
                r_s1_d <= w_d_in;

                r_s2_v <= r_s1_v;
                r_s2_a <= r_s1_a;
                r_s2_d <= r_s1_d;
                for (int k = 0; k < 4; k++) begin
                    r_s2_sq[k] <= D2_W'(r_s1_d[k]) * D2_W'(r_s1_d[k]);
                end

                r_s3_v  <= r_s2_v;
                r_s3_a  <= r_s2_a;
                r_s3_d  <= r_s2_d;
                r_s3_sq <= r_s2_sq;
                for (int k = 0; k < 4; k++) begin
                    r_s3_cu[k] <= D3_W'(r_s2_sq[k]) * D3_W'(r_s2_d[k]);
                end

                r_out_valid <= r_s3_v;
                r_w         <= w_res;
            end
        end
    end

    // Outer taps (distance 1..2) and inner taps (distance 0..1) use different cubic pieces.
    logic signed [C_W-1:0] w_a;
    logic signed [C_W-1:0] w_o3, w_o2, w_o1, w_o0;
    logic signed [C_W-1:0] w_i3, w_i2, w_i1, w_i0;

    assign w_a  = C_W'(r_s3_a);
    assign w_o3 = w_a;
    assign w_o2 = -((w_a <<< 2) + w_a);
    assign w_o1 = w_a <<< 3;
    assign w_o0 = -(w_a <<< 2);
    assign w_i3 = w_a + C_TWO;
    assign w_i2 = -(w_a + C_THREE);
    assign w_i1 = '0;
    assign w_i0 = C_ONE;

    for (genvar k = 0; k < 4; k++) begin : g_tap
        localparam bit OUTER = (k == 0) || (k == 3);
        logic signed [ACC_W-1:0] w_acc;

        bicubic_poly_eval #(
            .FRAC_W (FRAC_W),
            .C_W    (C_W),
            .D_W    (D_W),
            .ACC_W  (ACC_W)
        ) u_poly (
            .i_c3  (OUTER ? w_o3 : w_i3),
            .i_c2  (OUTER ? w_o2 : w_i2),
            .i_c1  (OUTER ? w_o1 : w_i1),
            .i_c0  (OUTER ? w_o0 : w_i0),
            .i_d   (r_s3_d[k]),
            .i_d2  (r_s3_sq[k]),
            .i_d3  (r_s3_cu[k]),
            .o_acc (w_acc)
        );

        assign w_res[k] = W_W'(sat_to_w(round_half_up(acc_t'(w_acc), 3 * FRAC_W), W_W));
    end

endmodule

// File: tb/tb_bicubic_weights.sv
// tb/tb_bicubic_weights.sv - scoreboard bench for bicubic_weights at default widths
module tb_bicubic_weights;

    localparam int FRAC_W = 8;
    localparam int A_W    = FRAC_W + 2;
    localparam int W_W    = FRAC_W + 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_we;
    logic signed [A_W-1:0] cfg_a;
    logic                  in_valid;
    logic                  in_ready;
    logic [FRAC_W-1:0]     in_t;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W_W-1:0] w0, w1, w2, w3;

    bicubic_weights dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_a     (cfg_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_t      (in_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int t;
    } samp_t;

    samp_t sb[$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    a_m      = -128;
    int    run      = 0;
    int    last_run = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic real kern(input int a_q, input int t_q, input int k);
        real a, t, d;
        a = a_q / 256.0;
        t = t_q / 256.0;
        case (k)
            0:       d = 1.0 + t;
            1:       d = t;
            2:       d = 1.0 - t;
            default: d = 2.0 - t;
        endcase
        if (k == 1 || k == 2) return (a + 2.0) * d * d * d - (a + 3.0) * d * d + 1.0;
        return a * d * d * d - 5.0 * a * d * d + 8.0 * a * d - 4.0 * a;
    endfunction

    function automatic int qround(input real r);
        int v;
        v = int'($floor(r * 256.0 + 0.5));
        if (v > 1023) v = 1023;
        if (v < -1024) v = -1024;
        return v;
    endfunction

    always @(negedge clk) begin : mon
        samp_t s;
        int    got [4];
        int    sum;
        real   r;
        if (rst) begin
            sb.delete();
            a_m = -128;
            run = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    s = sb.pop_front();
                    got[0] = w0; got[1] = w1; got[2] = w2; got[3] = w3;
                    sum = 0;
                    for (int k = 0; k < 4; k++) begin
                        r = kern(s.a, s.t, k) * 256.0;
                        check($sformatf("w%0d a=%0d t=%0d", k, s.a, s.t), got[k], qround(kern(s.a, s.t, k)));
                        check($sformatf("lsb%0d t=%0d", k, s.t),
                              (real'(got[k]) >= r - 1.0 && real'(got[k]) <= r + 1.0) ? 1 : 0, 1);
                        sum += got[k];
                    end
                    check($sformatf("sum t=%0d", s.t), (sum >= 254 && sum <= 258) ? 1 : 0, 1);
                end
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (in_valid && in_ready) begin
                s.a = cfg_we ? int'(cfg_a) : a_m;
                s.t = int'(in_t);
                sb.push_back(s);
            end
            if (cfg_we) a_m = cfg_a;
        end
    end

    task automatic send(input int t, input bit we, input int a);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_t     = FRAC_W'(t);
        cfg_we   = we;
        cfg_a    = A_W'(a);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int e0, input int e1, input int e2, input int e3);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, int'(out_valid), 1);
        check({tag, "_w0"}, w0, e0);
        check({tag, "_w1"}, w1, e1);
        check({tag, "_w2"}, w2, e2);
        check({tag, "_w3"}, w3, e3);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int h0, h1, h2, h3;
        int nv;
        rst = 1'b1; cfg_we = 1'b0; cfg_a = '0; in_valid = 1'b0; in_t = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_w0", w0, 0);
        check("rst_w1", w1, 0);
        check("rst_w2", w2, 0);
        check("rst_w3", w3, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        send(0, 1'b0, 0);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 4);
        check("t0_w0", w0, 0);
        check("t0_w1", w1, 256);
        check("t0_w2", w2, 0);
        check("t0_w3", w3, 0);
        idle(2);

        send(128, 1'b0, 0);
        expect_out("half", -16, 144, 144, -16);
        idle(2);

        send(128, 1'b0, 0);
        send(128, 1'b1, -256);
        expect_out("old_a", -16, 144, 144, -16);
        expect_out("new_a", -32, 160, 160, -32);
        idle(2);
        cfg_we = 1'b1; cfg_a = -128;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;

        for (int t = 0; t < 256; t++) send(t, 1'b0, 0);
        idle(10);
        check("sweep_run", last_run, 256);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10 + 20 * i, 1'b0, 0);
        h0 = w0; h1 = w1; h2 = w2; h3 = w3;
        in_valid = 1'b1;
        in_t     = 8'd77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_w0", w0, h0);
            check("stall_w1", w1, h1);
            check("stall_w2", w2, h2);
            check("stall_w3", w3, h3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(77, 1'b0, 0);
        idle(10);
        check("stall_drained", sb.size(), 0);

        send(40, 1'b0, 0);
        send(80, 1'b0, 0);
        send(120, 1'b0, 0);
        rst    = 1'b1;
        cfg_we = 1'b1;
        cfg_a  = -256;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        rst    = 1'b0;
        cfg_we = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("no_stale_out", nv, 0);
        @(posedge clk);
        #1;
        send(128, 1'b0, 0);
        expect_out("rst_a", -16, 144, 144, -16);
        idle(10);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
